sram_responder: RTL and testbench

//  Synthesizable device-side model of the board's 16-bit asynchronous SRAM (IS61WV102416-style pinout).
//  It answers the active-low CE/OE/WE/UB/LB bus driven by the audio sample controller (Final_Project_top),

---
 rtl/sram_responder.sv | 121 ++++++++++++
 tb/tb_sram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_responder
//  Function : Device-side model of a 16-bit asynchronous SRAM. It answers an
//             active-low CE/OE/WE/UB/LB bus, keeps the words in on-chip RAM,
//             and drives the shared tristate Data bus for reads after a fixed
//             latency. It also counts reads/writes and flags out-of-range use.
//  Revision : 1.0  initial release
// ============================================================================
module sram_responder #(
   parameter int          ADDR_W   = 20,
   parameter int          DATA_W   = 16,
   parameter int          DEPTH    = 65536,
   parameter int          READ_LAT = 1,
   parameter logic [15:0] OOB_DATA = 16'hDEAD
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] A,
   inout  wire  [DATA_W-1:0] Data,
   input  logic              CE_N,
   input  logic              OE_N,
   input  logic              WE_N,
   input  logic              UB_N,
   input  logic              LB_N,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
   output logic              oob_err
);

   localparam int IDX_W = $clog2(DEPTH);

   // Storage; deliberately never reset so contents survive Reset_n pulses.
   logic [DATA_W-1:0] mem [DEPTH];

   // Request decode on the live bus (WE wins over OE)
   logic sel;
   logic is_wr;
   logic is_rd;
   logic in_range;

   assign sel      = !CE_N && (!UB_N || !LB_N);
   assign is_wr    = sel && !WE_N;
   assign is_rd    = sel && WE_N && !OE_N;
   assign in_range = (32'(A) < 32'(DEPTH));

   // Read pipeline: each stage carries {valid, A, UB_N, LB_N}. The last stage
   // is the output stage; its data word is fetched as it is loaded, so writes
   // sampled on any earlier edge are already visible (write-first).
   logic [READ_LAT-1:0] p_valid;
   logic [READ_LAT-1:0] p_ub_n;
   logic [READ_LAT-1:0] p_lb_n;
   logic [ADDR_W-1:0]   p_addr [READ_LAT];
   logic [DATA_W-1:0]   out_data;

   // Inputs feeding the output stage
   logic              last_valid;
   logic [ADDR_W-1:0] last_addr;
   logic              last_in_range;

   generate
      if (READ_LAT == 1) begin : g_lat1
         assign last_valid = is_rd;
         assign last_addr  = A;
      end else begin : g_latn
         assign last_valid = p_valid[READ_LAT-2];
         assign last_addr  = p_addr[READ_LAT-2];
      end
   endgenerate

   assign last_in_range = (32'(last_addr) < 32'(DEPTH));

   // RAM write port: byte lanes written independently, out-of-range dropped
   always_ff @(posedge Clk) begin
      if (Reset_n && is_wr && in_range) begin
         if (!UB_N) mem[A[IDX_W-1:0]][DATA_W-1:8] <= Data[DATA_W-1:8];
         if (!LB_N) mem[A[IDX_W-1:0]][7:0]        <= Data[7:0];
      end
   end

   // Read pipeline, output data register, counters and sticky error flag
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         p_valid  <= '0;
         p_ub_n   <= '1;
         p_lb_n   <= '1;
         for (int i = 0; i < READ_LAT; i++) p_addr[i] <= '0;
         out_data <= '0;
         rd_count <= '0;
         wr_count <= '0;
         oob_err  <= 1'b0;
      end else begin
         p_valid[0] <= is_rd;
         p_addr[0]  <= A;
         p_ub_n[0]  <= UB_N;
         p_lb_n[0]  <= LB_N;
         for (int i = 1; i < READ_LAT; i++) begin
            p_valid[i] <= p_valid[i-1];
            p_addr[i]  <= p_addr[i-1];
            p_ub_n[i]  <= p_ub_n[i-1];
            p_lb_n[i]  <= p_lb_n[i-1];
         end
         if (last_valid) begin
            out_data <= last_in_range ? mem[last_addr[IDX_W-1:0]] : OOB_DATA;
         end
         // A read is counted as it starts driving, not when it is sampled
         if (last_valid && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
         if (is_wr && (wr_count != 16'hFFFF))      wr_count <= wr_count + 16'd1;
         if ((is_wr || is_rd) && !in_range)        oob_err  <= 1'b1;
      end
   end

   // Bus drive: only the enabled lanes of a valid output-stage read
   logic out_valid;
   assign out_valid = p_valid[READ_LAT-1];

   assign Data[DATA_W-1:8] = (out_valid && !p_ub_n[READ_LAT-1]) ? out_data[DATA_W-1:8] : 'z;
   assign Data[7:0]        = (out_valid && !p_lb_n[READ_LAT-1]) ? out_data[7:0]        : 'z;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_responder
//  Function : Directed self-checking bench for sram_responder (READ_LAT = 1).
//             Data has a pull-up, so a released lane reads back as 8'hFF.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_responder;

   localparam int DEPTH = 65536;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [19:0] A;
   logic        CE_N, OE_N, WE_N, UB_N, LB_N;
   logic [15:0] rd_count, wr_count;
   logic        oob_err;
   tri1  [15:0] Data;

   logic        tb_drv;
   logic [15:0] tb_data;

   int n_chk = 0;
   int n_bad = 0;

   assign Data = tb_drv ? tb_data : 16'hzzzz;

   sram_responder #(
      .ADDR_W(20), .DATA_W(16), .DEPTH(DEPTH), .READ_LAT(1), .OOB_DATA(16'hDEAD)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .A(A), .Data(Data),
      .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
      .rd_count(rd_count), .wr_count(wr_count), .oob_err(oob_err)
   );

   // Free-running clock
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      CE_N = 1'b1; OE_N = 1'b1; WE_N = 1'b1; UB_N = 1'b1; LB_N = 1'b1;
      tb_drv = 1'b0;
   endtask

   task automatic wr(input logic [19:0] addr, input logic [15:0] d,
                     input logic ub, input logic lb);
      A = addr; CE_N = 1'b0; WE_N = 1'b0; OE_N = 1'b1; UB_N = ub; LB_N = lb;
      tb_data = d; tb_drv = 1'b1;
   endtask

   task automatic rd(input logic [19:0] addr, input logic ub, input logic lb);
      A = addr; CE_N = 1'b0; WE_N = 1'b1; OE_N = 1'b0; UB_N = ub; LB_N = lb;
      tb_drv = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      A = '0; tb_data = '0;
      idle();
      Reset_n = 1'b0;
      tick(); tick();
      chk("rst_data",   Data,            16'hFFFF);
      chk("rst_rdcnt",  rd_count,        16'd0);
      chk("rst_wrcnt",  wr_count,        16'd0);
      chk("rst_oob",    {15'd0, oob_err}, 16'd0);
      Reset_n = 1'b1;
      tick();

      // Preload A=5, then reset again: RAM must survive, counter clears at once
      wr(20'd5, 16'h5A05, 1'b0, 1'b0); tick();
      idle(); tick();
      chk("pre_wrcnt", wr_count, 16'd1);
      Reset_n = 1'b0; #1;
      chk("rst_async_wrcnt", wr_count, 16'd0);
      tick(); Reset_n = 1'b1; tick();

      // Test 1: single read of A=5
      rd(20'd5, 1'b0, 1'b0);
      chk("t1_before", Data, 16'hFFFF);
      tick(); idle();
      chk("t1_data",  Data,     16'h5A05);
      chk("t1_rdcnt", rd_count, 16'd1);
      tick();
      chk("t1_after", Data,     16'hFFFF);

      // Test 2: write then read on the next edge (write-first)
      wr(20'h00010, 16'hA55A, 1'b0, 1'b0); tick();
      rd(20'h00010, 1'b0, 1'b0);           tick(); idle();
      chk("t2_data",  Data,     16'hA55A);
      chk("t2_wrcnt", wr_count, 16'd1);
      chk("t2_rdcnt", rd_count, 16'd2);
      tick();

      // Test 3: byte-lane writes and single-lane reads
      wr(20'h00020, 16'h1234, 1'b0, 1'b0); tick();
      wr(20'h00020, 16'hFFFF, 1'b1, 1'b0); tick();
      rd(20'h00020, 1'b0, 1'b0);           tick(); idle();
      chk("t3_lb_write", Data, 16'h12FF);
      tick();
      rd(20'h00010, 1'b0, 1'b1);           tick(); idle();
      chk("t3_ub_only", Data, 16'hA5FF);
      tick();
      rd(20'h00010, 1'b1, 1'b0);           tick(); idle();
      chk("t3_lb_only", Data, 16'hFF5A);
      chk("t3_rdcnt",   rd_count, 16'd5);
      tick();

      // Test 4: back-to-back reads, no gaps on the bus
      for (int i = 1; i <= 4; i++) begin
         wr(20'(i), 16'(i * 16'h1111), 1'b0, 1'b0); tick();
      end
      rd(20'd1, 1'b0, 1'b0); tick();
      rd(20'd2, 1'b0, 1'b0); chk("t4_w1", Data, 16'h1111); tick();
      rd(20'd3, 1'b0, 1'b0); chk("t4_w2", Data, 16'h2222); tick();
      rd(20'd4, 1'b0, 1'b0); chk("t4_w3", Data, 16'h3333); tick();
      idle();                chk("t4_w4", Data, 16'h4444);
      chk("t4_rdcnt", rd_count, 16'd9);
      tick();
      chk("t4_release", Data, 16'hFFFF);

      // Test 5: out-of-range write/read; A=DEPTH must not alias onto A=0
      wr(20'd0, 16'h0F0F, 1'b0, 1'b0);      tick();
      chk("t5_oob_clear", {15'd0, oob_err}, 16'd0);
      wr(20'(DEPTH), 16'hBEEF, 1'b0, 1'b0); tick(); idle();
      chk("t5_oob_wr",    {15'd0, oob_err}, 16'd1);
      chk("t5_wrcnt",     wr_count, 16'd9);
      rd(20'(DEPTH), 1'b0, 1'b0);           tick(); idle();
      chk("t5_oob_data",  Data,     16'hDEAD);
      chk("t5_rdcnt",     rd_count, 16'd10);
      tick();
      rd(20'd0, 1'b0, 1'b0);                tick(); idle();
      chk("t5_no_alias",  Data,     16'h0F0F);
      tick();
      chk("t5_oob_sticky", {15'd0, oob_err}, 16'd1);

      // Test 6: reset while a read is driving
      rd(20'h00010, 1'b0, 1'b0); tick(); idle();
      chk("t6_drv", Data, 16'hA55A);
      Reset_n = 1'b0; #1;
      chk("t6_rst_data",  Data,     16'hFFFF);
      chk("t6_rst_rdcnt", rd_count, 16'd0);
      chk("t6_rst_oob",   {15'd0, oob_err}, 16'd0);
      tick(); Reset_n = 1'b1; tick();
      chk("t6_post1", Data, 16'hFFFF);
      tick();
      chk("t6_post2",  Data,     16'hFFFF);
      chk("t6_rdcnt0", rd_count, 16'd0);
      rd(20'h00010, 1'b0, 1'b0); tick(); idle();
      chk("t6_ram_kept", Data,     16'hA55A);
      chk("t6_rdcnt1",   rd_count, 16'd1);
      tick();

      // Write counter saturation: WE held low for more than 65535 cycles
      wr(20'h00030, 16'h3030, 1'b0, 1'b0);
      repeat (65540) tick();
      idle();
      chk("sat_wrcnt", wr_count, 16'hFFFF);
      rd(20'h00030, 1'b0, 1'b0); tick(); idle();
      chk("sat_data", Data, 16'h3030);
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
